ps2_kbd_tx: RTL

PS/2 device-side transmitter. It serialises scancode bytes onto ps2_kbd_clk/ps2_kbd_data, the same lines the keyboard decoder consumes. The core uses it to inject virtual key events (OSD-generated coin/start, macro keys) and the benches use it as the keyboard model. Bytes enter through a small FIFO with a valid/ready handshake. Each byte is sent as a standard 11-bit frame, and the block honours host inhibit by aborting and retrying.

---
 rtl/ps2_kbd_tx_if.sv | 13 +
 rtl/ps2_kbd_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx_if.sv
// ps2_kbd_tx_if -- byte handshake into the PS/2 device-side transmitter.
//   tx_data  : scancode byte offered by the producer
//   tx_valid : byte offered; taken on a cycle with tx_valid & tx_ready
//   tx_ready : transmitter FIFO has room
// master = producer (core / bench), slave = ps2_kbd_tx.
interface ps2_kbd_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx -- PS/2 device-side transmitter.
// Queues scancode bytes in a small FIFO and sends each one as an 11-bit
// frame (start 0, data LSB first, odd parity, stop 1) on ps2_kbd_clk /
// ps2_kbd_data. If the host holds the clock low while we release it, the
// frame is aborted and the same byte is retried ahead of the FIFO.
// Ports:
//   clk_sys, res_n_i : clock, async active-low reset
//   tx_if            : byte handshake (tx_data / tx_valid / tx_ready)
//   ps2_clk_in       : sensed bus clock level (async, 1 when no host)
//   ps2_kbd_clk/data : driven line levels (1 = released)
//   busy             : queue, retry or frame/gap pending
//   frame_done       : 1-cycle pulse when a frame completes
//   tx_abort         : 1-cycle pulse when a frame is aborted by inhibit
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 720,
  parameter int GAP_HALVES = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic         clk_sys,
  input  logic         res_n_i,
  ps2_kbd_tx_if.slave  tx_if,
  input  logic         ps2_clk_in,
  output logic         ps2_kbd_clk,
  output logic         ps2_kbd_data,
  output logic         busy,
  output logic         frame_done,
  output logic         tx_abort
);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int GAP_CYC = GAP_HALVES * CLK_DIV;
  localparam int CNT_MAX = (GAP_CYC > 2 * CLK_DIV) ? GAP_CYC : 2 * CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         cur_byte_q, cur_byte_d;
  logic [7:0]         retry_byte_q, retry_byte_d;
  logic               retry_q, retry_d;
  logic               kclk_q, kclk_d;
  logic               kdat_q, kdat_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic               clk_meta_q, clk_s_q;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push, pop, inhibit;

  // Line level for frame position idx: 0 start, 1..8 data, 9 parity, 10 stop.
  function automatic logic bit_of(input logic [7:0] b, input logic [3:0] idx);
    if (idx == 4'd0)                     return 1'b0;
    else if (idx >= 4'd1 && idx <= 4'd8) return b[3'(idx - 4'd1)];
    else if (idx == 4'd9)                return ~^b;
    else                                 return 1'b1;
  endfunction

  // Host inhibit only counts while we ourselves release the clock; our own
  // low phase must not look like the host pulling it down.
  assign inhibit        = ~clk_s_q & kclk_q;
  assign tx_if.tx_ready = (count_q != (FIFO_AW+1)'(DEPTH));
  assign push           = tx_if.tx_valid & tx_if.tx_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    cur_byte_d   = cur_byte_q;
    retry_byte_d = retry_byte_q;
    retry_d      = retry_q;
    kclk_d       = kclk_q;
    kdat_d       = kdat_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!inhibit && (retry_q || count_q != '0)) begin
          // Retried byte always goes ahead of anything queued.
          cur_byte_d = retry_q ? retry_byte_q : mem_q[rd_ptr_q];
          pop        = ~retry_q;
          bit_idx_d  = 4'd0;
          kclk_d     = 1'b1;
          kdat_d     = 1'b0;
          cnt_d      = '0;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (inhibit && bit_idx_q != 4'd10) begin
          kclk_d       = 1'b1;
          kdat_d       = 1'b1;
          abort_d      = 1'b1;
          retry_byte_d = cur_byte_q;
          retry_d      = 1'b1;
          cnt_d        = '0;
          state_d      = HOLD;
        end else if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          kclk_d  = 1'b0;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          kclk_d = 1'b1;
          if (bit_idx_q == 4'd10) begin
            kdat_d  = 1'b1;
            done_d  = 1'b1;
            retry_d = 1'b0;
            state_d = GAP;
          end else begin
            // Data only changes as the clock goes back high.
            bit_idx_d = bit_idx_q + 4'd1;
            kdat_d    = bit_of(cur_byte_q, bit_idx_q + 4'd1);
            state_d   = HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // Wait for the bus clock to stay released for a full bit period.
        if (!clk_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign count_d  = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      cur_byte_q   <= '0;
      retry_byte_q <= '0;
      retry_q      <= 1'b0;
      kclk_q       <= 1'b1;
      kdat_q       <= 1'b1;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      clk_meta_q   <= 1'b1;
      clk_s_q      <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      cur_byte_q   <= cur_byte_d;
      retry_byte_q <= retry_byte_d;
      retry_q      <= retry_d;
      kclk_q       <= kclk_d;
      kdat_q       <= kdat_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      clk_meta_q   <= ps2_clk_in;
      clk_s_q      <= clk_meta_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count_q.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= tx_if.tx_data;
  end

  assign ps2_kbd_clk  = kclk_q;
  assign ps2_kbd_data = kdat_q;
  assign frame_done   = done_q;
  assign tx_abort     = abort_q;
  assign busy         = (state_q != IDLE) | (count_q != '0) | retry_q;
endmodule
